// File: rtl/mux_nx1_varredura.sv
// -----------------------------------------------------------------------------
// mux_nx1_varredura
// Registered N-to-1 multiplexer with an optional round-robin scan mode.
// In manual mode the channel comes from SEL. In varredura mode an internal
// index advances one channel every DWELL cycles and wraps after the last
// channel. It drives display/serial logic that has to cycle through values
// without an external sequencer.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset_n    in   synchronous active-low reset
//   D          in   packed channel data, channel k = D[k*BITS +: BITS]
//   SEL        in   manual channel select (out-of-range values are ignored)
//   MODO       in   0 = manual, 1 = varredura (auto scan)
//   PAUSA      in   freezes the scan counters in varredura
//   MUX_OUT    out  registered data of the selected channel
//   CANAL      out  index of the channel driving MUX_OUT
//   TROCA      out  one-cycle pulse, CANAL changed on the last edge
//   FIM_CICLO  out  one-cycle pulse, scan wrapped CHANNELS-1 -> 0
// -----------------------------------------------------------------------------
module mux_nx1_varredura #(
    parameter int BITS     = 4,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [CHANNELS*BITS-1:0] D,
    input  logic [SEL_W-1:0]         SEL,
    input  logic                     MODO,
    input  logic                     PAUSA,
    output logic [BITS-1:0]          MUX_OUT,
    output logic [SEL_W-1:0]         CANAL,
    output logic                     TROCA,
    output logic                     FIM_CICLO
);

    // The dwell counter keeps at least one bit so DWELL=1 still elaborates.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    // One extra bit so CHANNELS itself is representable for the range check.
    localparam logic [SEL_W:0]   NUM_CH   = (SEL_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    localparam logic [0:0] MODE_MANUAL    = 1'b0;
    localparam logic [0:0] MODE_VARREDURA = 1'b1;

    logic [SEL_W-1:0] r_canal;
    logic [CNT_W-1:0] r_cont;
    logic [BITS-1:0]  r_out;
    logic             r_troca;
    logic             r_fim;

    logic [SEL_W-1:0] w_canal_next;
    logic [CNT_W-1:0] w_cont_next;
    logic             w_wrap;
    logic [BITS-1:0]  w_data;
    logic [BITS-1:0]  w_ch [CHANNELS];

    // Unpack the flat data bus into one word per channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign w_ch[k] = D[k*BITS +: BITS];
    end

    // Next channel index and dwell count for the current mode.
    always_comb begin
        w_canal_next = r_canal;
        w_cont_next  = r_cont;
        w_wrap       = 1'b0;
        case (MODO)
            MODE_MANUAL: begin
                // Out-of-range selects keep the current channel rather than wrap.
                if ({1'b0, SEL} < NUM_CH) begin
                    w_canal_next = SEL;
                end else begin
                    w_canal_next = r_canal;
                end
                w_cont_next = {CNT_W{1'b0}};
            end
            MODE_VARREDURA: begin
                if (PAUSA) begin
                    w_canal_next = r_canal;
                    w_cont_next  = r_cont;
                end else if (r_cont != LAST_CNT) begin
                    w_canal_next = r_canal;
                    w_cont_next  = r_cont + CNT_W'(1);
                end else begin
                    w_cont_next = {CNT_W{1'b0}};
                    if (r_canal == LAST_CH) begin
                        w_canal_next = {SEL_W{1'b0}};
                        w_wrap       = 1'b1;
                    end else begin
                        w_canal_next = r_canal + SEL_W'(1);
                    end
                end
            end
            default: begin
                w_canal_next = r_canal;
                w_cont_next  = r_cont;
                w_wrap       = 1'b0;
            end
        endcase
    end

    // Data is taken from the channel that will be selected after this edge.
    always_comb begin
        w_data = w_ch[w_canal_next];
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_canal <= {SEL_W{1'b0}};
            r_cont  <= {CNT_W{1'b0}};
            r_out   <= {BITS{1'b0}};
            r_troca <= 1'b0;
            r_fim   <= 1'b0;
        end else begin
            r_canal <= w_canal_next;
            r_cont  <= w_cont_next;
            r_out   <= w_data;
            r_troca <= (w_canal_next != r_canal);
            r_fim   <= w_wrap;
        end
    end

    assign MUX_OUT   = r_out;
    assign CANAL     = r_canal;
    assign TROCA     = r_troca;
    assign FIM_CICLO = r_fim;

endmodule
